// File: rtl/switch_debouncer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : switch_debouncer_pkg
// Purpose : Shared types and helpers for the switch debouncer slice.
//           Holds the qualifier FSM state encoding and the width helper
//           for the qualify counter.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package switch_debouncer_pkg;

  // Qualifier FSM states.
  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  // Width of the qualify counter. It must hold values 0..stable_cycles-1.
  // The result is never allowed below 1 bit.
  function automatic int cnt_width(input int stable_cycles);
    int w;
    w = $clog2(stable_cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : switch_debouncer_pkg
`default_nettype wire

// File: rtl/switch_debouncer_if.sv
`default_nettype none
// ============================================================================
// Module  : switch_debouncer_if
// Purpose : Bundles the raw switch input and the conditioned outputs of the
//           debouncer.
// Ports   : switch_raw  - raw bouncy switch level (into the debouncer)
//           switch      - debounced level (out of the debouncer)
//           rise / fall - one-cycle accepted-edge pulses
//           busy        - candidate transition under qualification
//           press_count - wrapping count of accepted rises
//           master modport: the environment side (drives switch_raw)
//           slave  modport: the debouncer side (drives everything else)
// Revision: 1.0 - initial release
// ============================================================================
interface switch_debouncer_if #(
  parameter int COUNT_W = 8
);

  logic               switch_raw;
  logic               switch;
  logic               rise;
  logic               fall;
  logic               busy;
  logic [COUNT_W-1:0] press_count;

  modport master (
    output switch_raw,
    input  switch,
    input  rise,
    input  fall,
    input  busy,
    input  press_count
  );

  modport slave (
    input  switch_raw,
    output switch,
    output rise,
    output fall,
    output busy,
    output press_count
  );

endinterface : switch_debouncer_if
`default_nettype wire

// File: rtl/switch_debouncer_sync.sv
`default_nettype none
// ============================================================================
// Module  : switch_debouncer_sync (module name: switch_sync)
// Purpose : Multi-flop synchroniser that brings the asynchronous switch level
//           into the clk domain. All flops reset synchronously to
//           RESET_LEVEL.
// Ports   : clk - clock
//           rst - synchronous active-high reset
//           d   - asynchronous input level
//           q   - synchronised level (last stage of the chain)
// Revision: 1.0 - initial release
// ============================================================================
module switch_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic d,
  output logic      q
);

  import switch_debouncer_pkg::*;

  logic [SYNC_STAGES-1:0] r_chain;

  // Stage 0 samples the raw level. Each later stage takes the previous one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_chain <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = r_chain[SYNC_STAGES-1];

endmodule : switch_sync
`default_nettype wire

// File: rtl/switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module  : switch_debouncer
// Purpose : Turns a raw, bouncy switch level into a clean synchronous level.
//           The block also produces one-cycle rise/fall pulses, a busy flag
//           and a wrapping press counter. A new level is accepted only after
//           STABLE_CYCLES consecutive identical synchronised samples.
// Ports   : clk - clock, rising edge active
//           rst - synchronous active-high reset
//           bus - switch_debouncer_if.slave (switch_raw in; switch, rise,
//                 fall, busy, press_count out; all outputs registered)
// Revision: 1.0 - initial release
// ============================================================================
module switch_debouncer #(
  parameter int   SYNC_STAGES   = 2,
  parameter int   STABLE_CYCLES = 4,
  parameter int   COUNT_W       = 8,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  wire logic          clk,
  input  wire logic          rst,
  switch_debouncer_if.slave  bus
);

  import switch_debouncer_pkg::*;

  localparam int               CNT_W         = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] C_CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_CNT_LAST    = CNT_W'(STABLE_CYCLES - 1);
  localparam state_t           C_RESET_STATE = RESET_LEVEL ? HIGH : LOW;

  logic               w_sync;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_switch;
  logic               w_switch_nxt;
  logic               r_rise;
  logic               w_rise_nxt;
  logic               r_fall;
  logic               w_fall_nxt;
  logic               r_busy;
  logic               w_busy_nxt;
  logic [COUNT_W-1:0] r_press_count;
  logic [COUNT_W-1:0] w_press_count_nxt;

  switch_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_LEVEL (RESET_LEVEL)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.switch_raw),
    .q   (w_sync)
  );

  // State register plus the registered copies of every output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= C_RESET_STATE;
      r_cnt         <= '0;
      r_switch      <= RESET_LEVEL;
      r_rise        <= 1'b0;
      r_fall        <= 1'b0;
      r_busy        <= 1'b0;
      r_press_count <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_switch      <= w_switch_nxt;
      r_rise        <= w_rise_nxt;
      r_fall        <= w_fall_nxt;
      r_busy        <= w_busy_nxt;
      r_press_count <= w_press_count_nxt;
    end
  end

  // Next-state logic. The WAIT states count matching samples. The first
  // sample is taken when leaving the stable state, so the accept happens
  // on the STABLE_CYCLES-th consecutive matching sample. Any mismatch sends
  // the FSM back to the stable state and discards the partial count.
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_switch_nxt      = r_switch;
    w_rise_nxt        = 1'b0;
    w_fall_nxt        = 1'b0;
    w_press_count_nxt = r_press_count;

    case (r_state)
      LOW: begin
        w_switch_nxt = 1'b0;
        if (w_sync) begin
          w_state_nxt = WAIT_HIGH;
          w_cnt_nxt   = C_CNT_ONE;
        end else begin
          w_cnt_nxt   = '0;
        end
      end

      WAIT_HIGH: begin
        if (!w_sync) begin
          w_state_nxt = LOW;
          w_cnt_nxt   = '0;
        end else if (r_cnt == C_CNT_LAST) begin
          w_state_nxt       = HIGH;
          w_cnt_nxt         = '0;
          w_switch_nxt      = 1'b1;
          w_rise_nxt        = 1'b1;
          w_press_count_nxt = r_press_count + COUNT_W'(1);
        end else begin
          w_cnt_nxt   = r_cnt + C_CNT_ONE;
        end
      end

      HIGH: begin
        w_switch_nxt = 1'b1;
        if (!w_sync) begin
          w_state_nxt = WAIT_LOW;
          w_cnt_nxt   = C_CNT_ONE;
        end else begin
          w_cnt_nxt   = '0;
        end
      end

      WAIT_LOW: begin
        if (w_sync) begin
          w_state_nxt = HIGH;
          w_cnt_nxt   = '0;
        end else if (r_cnt == C_CNT_LAST) begin
          w_state_nxt  = LOW;
          w_cnt_nxt    = '0;
          w_switch_nxt = 1'b0;
          w_fall_nxt   = 1'b1;
        end else begin
          w_cnt_nxt    = r_cnt + C_CNT_ONE;
        end
      end

      default: begin
        w_state_nxt = C_RESET_STATE;
        w_cnt_nxt   = '0;
      end
    endcase

    // busy is registered, so it follows the state being entered.
    w_busy_nxt = (w_state_nxt == WAIT_HIGH) || (w_state_nxt == WAIT_LOW);
  end

  assign bus.switch      = r_switch;
  assign bus.rise        = r_rise;
  assign bus.fall        = r_fall;
  assign bus.busy        = r_busy;
  assign bus.press_count = r_press_count;

endmodule : switch_debouncer
`default_nettype wire

// File: tb/tb_switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module  : tb_switch_debouncer
// Purpose : Directed self-checking bench for switch_debouncer. Its DUT uses
//           COUNT_W=2, so press_count wraps after four presses. The bench
//           models the downstream inverter as the complement of switch.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_switch_debouncer;

  logic clk = 1'b0;
  logic rst;
  logic inv_out;
  int   checks = 0;
  int   errors = 0;

  switch_debouncer_if #(.COUNT_W(2)) bus ();

  switch_debouncer #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (4),
    .COUNT_W       (2),
    .RESET_LEVEL   (1'b0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  assign inv_out = ~bus.switch;

  always #5 clk = ~clk;

  // Advance one rising edge; observe 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clean press followed by one clean release. With 2 sync stages and
  // 4 stable cycles, each accept lands on the 6th edge after the change.
  task automatic press_release(input int exp_pc);
    bus.switch_raw = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("wrap_rise", 32'(bus.rise), 32'(i == 6));
      check("wrap_no_overlap", 32'(bus.rise & bus.fall), 32'd0);
    end
    check("wrap_switch_hi", 32'(bus.switch), 32'd1);
    check("wrap_press_count", 32'(bus.press_count), 32'(exp_pc));
    tick();
    check("wrap_rise_once", 32'(bus.rise), 32'd0);
    bus.switch_raw = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("wrap_fall", 32'(bus.fall), 32'(i == 6));
      check("wrap_no_overlap", 32'(bus.rise & bus.fall), 32'd0);
    end
    check("wrap_switch_lo", 32'(bus.switch), 32'd0);
    check("wrap_count_hold", 32'(bus.press_count), 32'(exp_pc));
    tick();
    check("wrap_fall_once", 32'(bus.fall), 32'd0);
  endtask

  initial begin
    int  n_rise;
    int  n_fall;
    bit  saw_busy;
    bit  saw_switch;

    // Reset held 3 cycles with the raw input high.
    rst = 1'b1;
    bus.switch_raw = 1'b1;
    repeat (3) tick();
    check("reset_switch", 32'(bus.switch), 32'd0);
    check("reset_rise", 32'(bus.rise), 32'd0);
    check("reset_fall", 32'(bus.fall), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_press_count", 32'(bus.press_count), 32'd0);
    check("reset_inverter", 32'(inv_out), 32'd1);

    rst = 1'b0;
    bus.switch_raw = 1'b0;
    repeat (4) tick();
    check("idle_switch", 32'(bus.switch), 32'd0);
    check("idle_busy", 32'(bus.busy), 32'd0);

    // Clean press. The FSM first sees the new level on edge 3, so busy is
    // high after edges 3..5. The accept happens on edge 6.
    bus.switch_raw = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("press_switch", 32'(bus.switch), 32'(i == 6));
      check("press_rise", 32'(bus.rise), 32'(i == 6));
      check("press_busy", 32'(bus.busy), 32'(i >= 3 && i <= 5));
    end
    check("press_count_1", 32'(bus.press_count), 32'd1);
    check("press_inverter", 32'(inv_out), 32'd0);
    tick();
    check("press_rise_once", 32'(bus.rise), 32'd0);
    check("press_switch_hold", 32'(bus.switch), 32'd1);

    // Clean release.
    bus.switch_raw = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("release_switch", 32'(bus.switch), 32'(i != 6));
      check("release_fall", 32'(bus.fall), 32'(i == 6));
    end
    check("release_count", 32'(bus.press_count), 32'd1);
    repeat (2) tick();

    // Glitch: high for 3 cycles only.
    saw_busy   = 1'b0;
    saw_switch = 1'b0;
    n_rise     = 0;
    bus.switch_raw = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      if (i == 4) bus.switch_raw = 1'b0;
      tick();
      if (bus.busy)   saw_busy = 1'b1;
      if (bus.switch) saw_switch = 1'b1;
      if (bus.rise)   n_rise++;
    end
    check("glitch_busy_seen", 32'(saw_busy), 32'd1);
    check("glitch_busy_clear", 32'(bus.busy), 32'd0);
    check("glitch_switch", 32'(saw_switch), 32'd0);
    check("glitch_no_rise", 32'(n_rise), 32'd0);
    check("glitch_count", 32'(bus.press_count), 32'd1);

    // Bounce 1,0,1,0 and then a steady 1.
    n_rise = 0;
    bus.switch_raw = 1'b1; tick(); if (bus.rise) n_rise++;
    bus.switch_raw = 1'b0; tick(); if (bus.rise) n_rise++;
    bus.switch_raw = 1'b1; tick(); if (bus.rise) n_rise++;
    bus.switch_raw = 1'b0; tick(); if (bus.rise) n_rise++;
    bus.switch_raw = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (bus.rise) n_rise++;
      check("bounce_switch", 32'(bus.switch), 32'(i >= 6));
      check("bounce_rise", 32'(bus.rise), 32'(i == 6));
    end
    check("bounce_one_rise", 32'(n_rise), 32'd1);
    check("bounce_count", 32'(bus.press_count), 32'd2);

    // Release after the bounce.
    n_fall = 0;
    bus.switch_raw = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (bus.fall) n_fall++;
    end
    check("bounce_release_fall", 32'(n_fall), 32'd1);
    check("bounce_release_switch", 32'(bus.switch), 32'd0);

    // Wrap test starts from a cleared counter.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("wrap_start_count", 32'(bus.press_count), 32'd0);
    press_release(1);
    press_release(2);
    press_release(3);
    press_release(0);
    press_release(1);

    // Reset while qualifying a rise.
    bus.switch_raw = 1'b1;
    repeat (4) tick();
    check("midwait_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    bus.switch_raw = 1'b0;
    tick();
    check("midwait_switch", 32'(bus.switch), 32'd0);
    check("midwait_rise", 32'(bus.rise), 32'd0);
    check("midwait_busy_clear", 32'(bus.busy), 32'd0);
    check("midwait_count", 32'(bus.press_count), 32'd0);
    rst = 1'b0;
    n_rise = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (bus.rise || bus.switch) n_rise++;
    end
    check("midwait_no_late_rise", 32'(n_rise), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_switch_debouncer
`default_nettype wire

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Conditions a raw, asynchronous, bouncy mechanical switch level into a clean, clock-synchronous `switch` signal.
- Sits directly upstream of the CMOS inverter stage; its `switch` output drives the inverter's `switch` input.
- Also emits one-cycle rise/fall pulses, a busy flag and a wrapping press counter for bench observation.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on `switch_raw`; legal range ≥2.
- STABLE_CYCLES, 4, consecutive synchronised samples required to accept a new level; legal range ≥2.
- COUNT_W, 8, width of `press_count`.
- RESET_LEVEL, 0, level of `switch` and of every synchroniser flop during and after reset.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- switch_raw  input  1  asynchronous raw switch level, may bounce.
- switch  output  1  debounced level; feeds the inverter.
- rise  output  1  one-cycle pulse on an accepted 0→1 transition.
- fall  output  1  one-cycle pulse on an accepted 1→0 transition.
- busy  output  1  high while a candidate transition is being qualified.
- press_count  output  COUNT_W  number of accepted rises, modulo 2^COUNT_W.

Behaviour:
- Reset: one clock, synchronous, active-high; rst wins over every other event in the same cycle.
  - switch=RESET_LEVEL, rise=0, fall=0, busy=0, press_count=0.
  - Synchroniser flops = RESET_LEVEL; qualify counter cnt=0; state = LOW if RESET_LEVEL=0, else HIGH.
- Synchroniser: a shift chain of SYNC_STAGES flops; `sync` is the last stage. Nothing else samples `switch_raw`.
- FSM states: LOW, WAIT_HIGH, HIGH, WAIT_LOW (encoding in package).
  - LOW: switch=0. If sync=1 → WAIT_HIGH, cnt=1. Otherwise stay, cnt=0.
  - WAIT_HIGH: switch=0, busy=1.
    - If sync=0 → LOW, cnt=0 (bounce discarded, no pulse).
    - Else if cnt==STABLE_CYCLES-1 → HIGH, switch=1, rise=1 for one cycle, press_count+1.
    - Else cnt+1.
  - HIGH and WAIT_LOW: mirror of LOW and WAIT_HIGH. The accept step sets switch=0 and fall=1; press_count is unchanged.
- Latency:
  - `switch_raw` changes before edge N and stays stable → `switch` and its pulse update on edge N+SYNC_STAGES+STABLE_CYCLES-1.
  - With the defaults this is edge N+5.
- A pulse of `switch_raw` lasting fewer than STABLE_CYCLES cycles after synchronisation never changes `switch`.
- Bounce during WAIT restarts qualification from zero; any partial count is discarded.
- rise and fall are never high in the same cycle; a pulse is never repeated without a new qualified transition.
- press_count wraps from 2^COUNT_W-1 to 0 silently.
- Reset mid-WAIT aborts the candidate transition: no pulse, and press_count is cleared.
- All outputs are registered; no combinational path from `switch_raw` to any output.

Decomposition:
- Package `switch_debouncer_pkg`:
  - state typedef/localparams LOW=2'd0, WAIT_HIGH=2'd1, HIGH=2'd2, WAIT_LOW=2'd3;
  - helper constant for cnt width = $clog2(STABLE_CYCLES).
- Sub-module `switch_sync`: parameterised SYNC_STAGES flop chain with synchronous reset to RESET_LEVEL.
- FSM, counter and pulse logic stay in the top.

Test Plan:
- Reset: hold rst 3 cycles with switch_raw=1 → switch=0, rise=fall=busy=0, press_count=0; inverter result=1.
- Clean press: switch_raw 0→1 before edge 10, held high → switch=1 after edge 15; rise high exactly one cycle after edge 15; press_count=1; inverter result=0.
- Glitch: switch_raw high for 3 cycles, then low → switch stays 0; busy rises then clears; no rise pulse; press_count unchanged.
- Bounce: switch_raw toggles 1,0,1,0,1 on consecutive cycles, then stays 1 → switch=1 exactly 6 edges after the final 0→1; exactly one rise pulse.
- Release and wrap: with COUNT_W=2, do 5 clean press/release pairs → press_count sequence 1,2,3,0,1; one fall pulse per release; rise and fall never overlap.
- Reset mid-WAIT: assert rst while busy=1 in WAIT_HIGH → next cycle state LOW, switch=0, no rise pulse, press_count=0.
